// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared constants for the data-memory arbiter: FSM state
//               encoding, active-low byte-lane write-enable patterns, bus
//               widths and the host-burst address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 32;
   localparam int LANE_W      = 4;
   localparam int BEAT_W      = 4;
   localparam int STALL_CNT_W = 16;
   localparam int BURST_CNT_W = 8;

   // Arbiter FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HOST  = 2'd1;
   localparam logic [1:0] ST_YIELD = 2'd2;

   // Byte-lane write enables are active-low
   localparam logic [LANE_W-1:0] WREN_NONE = 4'b1111;
   localparam logic [LANE_W-1:0] WREN_ALL  = 4'b0000;

   // Burst beat address; wraps naturally at the top of the word space
   function automatic logic [ADDR_W-1:0] beat_addr(
      input logic [ADDR_W-1:0] base,
      input logic [BEAT_W-1:0] beat
   );
      return base + {{(ADDR_W-BEAT_W){1'b0}}, beat};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_stats.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_stats
// Description : Arbiter statistics: saturating count of CPU stall cycles and
//               wrapping count of completed host bursts. Only instantiated
//               when DMEM_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_stats
   import dmem_arb_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstd,
   input  logic                   cpu_stall,
   input  logic                   host_done,
   output logic [STALL_CNT_W-1:0] stat_stall_cycles,
   output logic [BURST_CNT_W-1:0] stat_bursts
);

   localparam logic [STALL_CNT_W-1:0] c_stall_max = '1;

   // Count stalled CPU cycles (saturating) and finished bursts (wrapping)
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         stat_stall_cycles <= '0;
         stat_bursts       <= '0;
      end else begin
         if (cpu_stall && (stat_stall_cycles != c_stall_max))
            stat_stall_cycles <= stat_stall_cycles + 1'b1;
         if (host_done)
            stat_bursts <= stat_bursts + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the byte-laned data memory between the CPU load/store
//               path and a host burst port. The CPU owns the port while idle;
//               a host burst takes one word per cycle and stalls the CPU, with
//               forced one-cycle yields after STARVE_LIMIT stalled cycles.
//               Optional statistics outputs: define DMEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)
(
   input  logic                   clk,
   input  logic                   rstd,
   input  logic                   cpu_req,
   input  logic [ADDR_W-1:0]      cpu_addr,
   input  logic [DATA_W-1:0]      cpu_wdata,
   input  logic [LANE_W-1:0]      cpu_wren,
   output logic                   cpu_stall,
   output logic [DATA_W-1:0]      cpu_rdata,
   input  logic                   host_req,
   input  logic                   host_we,
   input  logic [ADDR_W-1:0]      host_addr,
   input  logic [BEAT_W-1:0]      host_len,
   input  logic [DATA_W-1:0]      host_wdata,
   output logic                   host_ack,
   output logic [DATA_W-1:0]      host_rdata,
   output logic                   host_done,
   output logic                   host_busy,
`ifdef DMEM_ARB_STATS_EN
   output logic [STALL_CNT_W-1:0] stat_stall_cycles,
   output logic [BURST_CNT_W-1:0] stat_bursts,
`endif
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   output logic [LANE_W-1:0]      mem_wren,
   input  logic [DATA_W-1:0]      mem_rdata
);

   // Starve counter value at which a stalled cycle triggers a yield
   localparam logic [BEAT_W-1:0] c_starve_max = BEAT_W'(STARVE_LIMIT - 1);

   logic [1:0]        r_state;
   logic [BEAT_W-1:0] r_beat;
   logic [BEAT_W-1:0] r_starve;
   logic [ADDR_W-1:0] r_base;
   logic [BEAT_W-1:0] r_len;
   logic              r_we;

   logic              w_last_beat;
   logic              w_yield_now;

   assign w_last_beat = (r_beat == r_len);
   assign w_yield_now = cpu_req && (r_starve == c_starve_max);

   // Arbiter FSM with burst beat and starvation counters
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r_state  <= ST_IDLE;
         r_beat   <= '0;
         r_starve <= '0;
         r_base   <= '0;
         r_len    <= '0;
         r_we     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (host_req) begin
                  r_base   <= host_addr;
                  r_len    <= host_len;
                  r_we     <= host_we;
                  r_beat   <= '0;
                  r_starve <= '0;
                  r_state  <= ST_HOST;
               end
            end
            ST_HOST: begin
               r_beat   <= r_beat + 1'b1;
               r_starve <= cpu_req ? (r_starve + 1'b1) : '0;
               if (w_last_beat)
                  r_state <= ST_IDLE;
               else if (w_yield_now)
                  r_state <= ST_YIELD;
            end
            ST_YIELD: begin
               r_starve <= '0;
               r_state  <= ST_HOST;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Memory port mux and handshake outputs; writes are blocked while in reset
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wren  = cpu_wren;
      cpu_stall = 1'b0;
      host_ack  = 1'b0;
      host_done = 1'b0;
      if (r_state == ST_HOST) begin
         mem_addr  = beat_addr(r_base, r_beat);
         mem_wdata = host_wdata;
         mem_wren  = r_we ? WREN_ALL : WREN_NONE;
         cpu_stall = cpu_req;
         host_ack  = 1'b1;
         host_done = w_last_beat;
      end
      if (!rstd)
         mem_wren = WREN_NONE;
   end

   assign host_busy  = (r_state == ST_HOST) || (r_state == ST_YIELD);
   assign host_rdata = mem_rdata;
   assign cpu_rdata  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
   dmem_arb_stats u_stats (
      .clk               (clk),
      .rstd              (rstd),
      .cpu_stall         (cpu_stall),
      .host_done         (host_done),
      .stat_stall_cycles (stat_stall_cycles),
      .stat_bursts       (stat_bursts)
   );
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a behavioural memory,
//               a reference memory image and burst timing derived from the
//               arbitration rules. Stats outputs checked under
//               DMEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        rstd = 1'b0;
   logic        preload = 1'b1;
   logic        cpu_req = 1'b0;
   logic [7:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [3:0]  cpu_wren = 4'hf;
   logic        cpu_stall;
   logic [31:0] cpu_rdata;
   logic        host_req = 1'b0;
   logic        host_we = 1'b0;
   logic [7:0]  host_addr = '0;
   logic [3:0]  host_len = '0;
   logic [31:0] host_wdata = '0;
   logic        host_ack;
   logic [31:0] host_rdata;
   logic        host_done;
   logic        host_busy;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wren;
   logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_stall_cycles;
   logic [7:0]  stat_bursts;
`endif

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rstd(rstd),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_wren(cpu_wren), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_len(host_len), .host_wdata(host_wdata), .host_ack(host_ack),
      .host_rdata(host_rdata), .host_done(host_done), .host_busy(host_busy),
`ifdef DMEM_ARB_STATS_EN
      .stat_stall_cycles(stat_stall_cycles), .stat_bursts(stat_bursts),
`endif
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] pre_val(input int i);
      return (i * 32'h9e3779b1) ^ 32'h5a5a_0f0f;
   endfunction

   // Behavioural byte-laned data memory
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= pre_val(i);
      end else begin
         for (int l = 0; l < 4; l++)
            if (!mem_wren[l]) mem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
      end
   end
   assign mem_rdata = mem[mem_addr];

   // Reference image and scoreboard queues
   logic [31:0] ref_mem [256];
   logic [31:0] q_cpu[$];
   logic [31:0] q_host[$];
   logic [7:0]  q_addr[$];
   int          q_done[$];
   bit          burst_we = 1'b0;
   int          total = 0;
   int          bad = 0;
   int          exp_stalls = 0;
   int          exp_bursts = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event, expected none", name);
   endtask

   // Monitor: pops expectations whenever the DUT presents a response
   initial begin : monitor
      int busy_cnt;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rstd) begin
            busy_cnt = 0;
         end else begin
            if (cpu_req && !cpu_stall && cpu_wren == 4'hf) begin
               if (q_cpu.size() == 0) fail_now("cpu_read_unexpected");
               else chk("cpu_rdata", cpu_rdata, q_cpu.pop_front());
            end
            if (host_busy && !cpu_req) chk("cpu_stall_no_req", {31'd0, cpu_stall}, 32'd0);
            if (host_ack) begin
               if (q_addr.size() == 0) fail_now("host_ack_unexpected");
               else chk("beat_addr", {24'd0, mem_addr}, {24'd0, q_addr.pop_front()});
               chk("beat_wren", {28'd0, mem_wren}, burst_we ? 32'h0 : 32'hf);
               if (!burst_we) begin
                  if (q_host.size() == 0) fail_now("host_rdata_unexpected");
                  else chk("host_rdata", host_rdata, q_host.pop_front());
               end
            end
            if (host_busy) busy_cnt++;
            if (host_done) begin
               if (q_done.size() == 0) fail_now("host_done_unexpected");
               else chk("burst_cycles", busy_cnt, q_done.pop_front());
               busy_cnt = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic cpu_op(input bit st, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] wr);
      cpu_req   = 1'b1;
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_wren  = st ? wr : 4'hf;
      if (st) begin
         for (int l = 0; l < 4; l++)
            if (!wr[l]) ref_mem[a][8*l +: 8] = d[8*l +: 8];
      end else begin
         q_cpu.push_back(ref_mem[a]);
      end
      @(negedge clk);
      chk("cpu_stall_idle", {31'd0, cpu_stall}, 32'd0);
      @(posedge clk); #1;
      cpu_req  = 1'b0;
      cpu_wren = 4'hf;
   endtask

   // mode 0: CPU quiet, 1: CPU load held high, 2: random CPU load requests
   task automatic run_burst(input bit we, input logic [7:0] base, input logic [3:0] len,
                            input int mode);
      logic [31:0] wd [16];
      bit          p [32];
      logic [7:0]  caddr, a;
      int          beat, cyc, run, idx, k;
      bit          ack, done;
      caddr = base + 8'd128;
      for (int i = 0; i < 32; i++)
         p[i] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wd[i] = $urandom;
         a = base + 8'(i);
         q_addr.push_back(a);
         if (we) ref_mem[a] = wd[i];
         else q_host.push_back(ref_mem[a]);
      end
      // Cycle-level outcome: one beat per host cycle, and a yield cycle after
      // STARVE_LIMIT consecutive stalled cycles unless the beat was the last
      beat = 0; cyc = 0; run = 0;
      forever begin
         if (p[cyc]) begin run++; exp_stalls++; end else run = 0;
         cyc++;
         if (beat == int'(len)) break;
         beat++;
         if (p[cyc-1] && run == STARVE_LIMIT) begin
            if (p[cyc]) q_cpu.push_back(ref_mem[caddr]);
            cyc++;
            run = 0;
         end
      end
      q_done.push_back(cyc);
      exp_bursts++;

      burst_we   = we;
      host_req   = 1'b1;
      host_we    = we;
      host_addr  = base;
      host_len   = len;
      host_wdata = wd[0];
      cpu_req    = 1'b0;
      @(posedge clk); #1;
      host_req  = 1'b0;
      host_we   = 1'($urandom);
      host_addr = 8'($urandom);
      host_len  = 4'($urandom);
      cpu_addr  = caddr;
      cpu_wren  = 4'hf;
      idx = 0; k = 0; done = 1'b0;
      while (!done && k < 40) begin
         cpu_req    = (k < 32) ? p[k] : 1'b0;
         host_wdata = (idx < 16) ? wd[idx] : 32'h0;
         @(negedge clk);
         ack  = host_ack;
         done = host_done;
         @(posedge clk); #1;
         if (ack) idx++;
         k++;
      end
      cpu_req = 1'b0;
      if (!done) fail_now("burst_timeout");
   endtask

   task automatic idle_checks(input string tag);
      chk({tag, "_mem_wren"},  {28'd0, mem_wren}, 32'hf);
      chk({tag, "_cpu_stall"}, {31'd0, cpu_stall}, 32'd0);
      chk({tag, "_host_ack"},  {31'd0, host_ack}, 32'd0);
      chk({tag, "_host_done"}, {31'd0, host_done}, 32'd0);
      chk({tag, "_host_busy"}, {31'd0, host_busy}, 32'd0);
   endtask

   initial begin : stim
      logic [7:0]  a, b;
      logic [31:0] w, d;
      int          r;
      for (int i = 0; i < 256; i++) ref_mem[i] = pre_val(i);

      // Reset with an active CPU store on the bus
      cpu_req   = 1'b1;
      cpu_wren  = 4'b0000;
      cpu_addr  = 8'd8;
      cpu_wdata = 32'h1234_5678;
      repeat (3) @(posedge clk);
      @(negedge clk);
      idle_checks("reset");
      #1 preload = 1'b0;
      @(posedge clk); #1;
      cpu_req  = 1'b0;
      cpu_wren = 4'hf;
      rstd     = 1'b1;
      @(posedge clk); #1;

      // CPU store then load, zero latency
      cpu_op(1'b1, 8'd8, 32'hdeadbeef, 4'b0000);
      cpu_op(1'b0, 8'd8, 32'h0, 4'hf);

      // Wrapping write burst with a quiet CPU
      begin : wrap_burst
         logic [31:0] dv [4];
         dv[0] = 32'd1; dv[1] = 32'd2; dv[2] = 32'd3; dv[3] = 32'd4;
         q_done.push_back(4);
         exp_bursts++;
         for (int i = 0; i < 4; i++) begin
            a = 8'hfe + 8'(i);
            q_addr.push_back(a);
            ref_mem[a] = dv[i];
         end
         burst_we   = 1'b1;
         host_req   = 1'b1;
         host_we    = 1'b1;
         host_addr  = 8'hfe;
         host_len   = 4'd3;
         @(posedge clk); #1;
         host_req = 1'b0;
         for (int i = 0; i < 4; i++) begin
            host_wdata = dv[i];
            @(posedge clk); #1;
         end
         cpu_op(1'b0, 8'hfe, 32'h0, 4'hf);
         cpu_op(1'b0, 8'hff, 32'h0, 4'hf);
         cpu_op(1'b0, 8'h00, 32'h0, 4'hf);
         cpu_op(1'b0, 8'h01, 32'h0, 4'hf);
      end

      // 16-beat read burst against a CPU that never lets go
      run_burst(1'b0, 8'h40, 4'd15, 1);

      // Host request and CPU store in the same idle cycle
      a = 8'h20; b = 8'h60; w = $urandom; d = $urandom;
      q_addr.push_back(a); ref_mem[a] = w; q_done.push_back(1); exp_bursts++;
      ref_mem[b] = d;
      burst_we  = 1'b1;
      host_req  = 1'b1; host_we = 1'b1; host_addr = a; host_len = 4'd0; host_wdata = w;
      cpu_req   = 1'b1; cpu_addr = b; cpu_wdata = d; cpu_wren = 4'b0000;
      @(negedge clk);
      chk("same_cycle_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      chk("same_cycle_host_ack",  {31'd0, host_ack}, 32'd0);
      chk("same_cycle_mem_addr",  {24'd0, mem_addr}, {24'd0, b});
      @(posedge clk); #1;
      host_req = 1'b0; cpu_req = 1'b0; cpu_wren = 4'hf;
      @(negedge clk);
      chk("same_cycle_first_beat", {31'd0, host_ack}, 32'd1);
      @(posedge clk); #1;

      // Reset asserted during beat 2 of a 6-beat write burst
      begin : abort_burst
         logic [31:0] wd [6];
         a = 8'h90;
         for (int i = 0; i < 6; i++) wd[i] = $urandom;
         for (int i = 0; i < 2; i++) begin
            q_addr.push_back(a + 8'(i));
            ref_mem[a + 8'(i)] = wd[i];
         end
         burst_we  = 1'b1;
         host_req  = 1'b1; host_we = 1'b1; host_addr = a; host_len = 4'd5;
         @(posedge clk); #1;
         host_req = 1'b0;
         for (int i = 0; i < 2; i++) begin
            host_wdata = wd[i];
            @(posedge clk); #1;
         end
         host_wdata = wd[2];
         #1 rstd = 1'b0;
         exp_stalls = 0;
         exp_bursts = 0;
         #1 idle_checks("abort");
         @(posedge clk); #1;
         rstd = 1'b1;
         for (int i = 0; i < 4; i++) begin
            host_wdata = wd[2 + i];
            @(negedge clk);
            chk("abort_host_busy", {31'd0, host_busy}, 32'd0);
            chk("abort_host_ack",  {31'd0, host_ack}, 32'd0);
            @(posedge clk); #1;
         end
      end

      // Randomized mix of CPU accesses and bursts
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 4);
         case (r)
            0: cpu_op(1'b1, 8'($urandom), $urandom, 4'($urandom_range(0, 14)));
            1: cpu_op(1'b0, 8'($urandom), 32'h0, 4'hf);
            4: run_burst(1'($urandom), 8'($urandom), 4'($urandom), 1);
            default: run_burst(1'($urandom), 8'($urandom), 4'($urandom), 2);
         endcase
      end
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
      chk("q_cpu_left",  q_cpu.size(), 0);
      chk("q_host_left", q_host.size(), 0);
      chk("q_addr_left", q_addr.size(), 0);
      chk("q_done_left", q_done.size(), 0);
`ifdef DMEM_ARB_STATS_EN
      chk("stat_stall_cycles", {16'd0, stat_stall_cycles}, 32'(exp_stalls));
      chk("stat_bursts", {24'd0, stat_bursts}, {24'd0, 8'(exp_bursts)});
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the 32-bit, four-byte-lane data memory between the CPU load/store path and a host burst port, used for program loading, memory dumps and debug. The CPU has priority while the arbiter is idle. A host burst takes the port one word per cycle and stalls the CPU. A starvation limit forces periodic single-cycle yields to the CPU so it cannot be locked out. The block sits between `execute` and the four `data_mem` byte instances.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive stalled CPU cycles allowed before a forced yield (range 1–15).

Ports:
- `clk` in 1: clock.
- `rstd` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU issues a load or store this cycle.
- `cpu_addr` in 8: CPU word address.
- `cpu_wdata` in 32: CPU store data.
- `cpu_wren` in 4: CPU byte-lane write enables, active-low.
- `cpu_stall` out 1: CPU must hold PC and suppress register writeback.
- `cpu_rdata` out 32: read data to CPU.
- `host_req` in 1: host burst request, level.
- `host_we` in 1: 1 = write burst, 0 = read burst.
- `host_addr` in 8: burst base word address.
- `host_len` in 4: beats minus 1 (0 means 1 beat, 15 means 16 beats).
- `host_wdata` in 32: current write beat data.
- `host_ack` out 1: a beat is consumed or produced this cycle.
- `host_rdata` out 32: read beat data, valid while `host_ack` is high on a read burst.
- `host_done` out 1: final beat this cycle.
- `host_busy` out 1: a burst is in progress.
- `mem_addr` out 8: memory word address.
- `mem_wdata` out 32: memory write data.
- `mem_wren` out 4: memory byte-lane write enables, active-low.
- `mem_rdata` in 32: combinational read data from memory.

## Operation
- FSM states:
  - IDLE: CPU owns the port.
  - HOST: host owns the port.
  - YIELD: CPU owns the port for exactly one cycle, then returns to HOST.
- IDLE:
  - Memory port driven from `cpu_*`; `cpu_stall`=0.
  - `host_req`=1 at a posedge latches `host_addr`, `host_len` and `host_we`, clears the beat and starve counters, and moves to HOST.
  - `host_req` is sampled only in IDLE.
- HOST:
  - `mem_addr` = base + beat, modulo 256 (wraps 255→0).
  - `mem_wren`=4'b0000 for a write burst, 4'b1111 for a read burst.
  - `mem_wdata`=`host_wdata`; `host_ack`=1; `host_rdata`=`mem_rdata`.
  - `cpu_stall`=`cpu_req`.
  - Beat counter increments every HOST cycle.
  - Starve counter increments when `cpu_req`=1 and clears when `cpu_req`=0.
- Transitions out of HOST, in priority order:
  - Final beat (beat == len): assert `host_done`, go to IDLE.
  - Otherwise, starve counter reaches `STARVE_LIMIT`−1 with `cpu_req`=1: go to YIELD.
  - Otherwise: stay in HOST.
- YIELD:
  - CPU drives the port; `cpu_stall`=0; `host_ack`=0.
  - Starve counter cleared; next state HOST, beat counter unchanged.
- `cpu_rdata`=`mem_rdata` always. The CPU must ignore it while stalled.
- `host_busy`=1 in HOST and YIELD.
- The host must keep `host_req` low after `host_done` to avoid an immediate new burst, since `host_req` is a level.

## Timing
- All outputs are combinational from registered state and the current inputs. Memory writes commit at the posedge ending the cycle.
- CPU access latency is 0 cycles when not stalled.
- Host first beat occurs one cycle after `host_req` is sampled in IDLE. A burst of N beats completes in N cycles plus the number of yields.
- If `cpu_req` and `host_req` are both high in IDLE, the CPU is served that cycle and the host begins next cycle.
- Reset values:
  - State IDLE; counters 0.
  - `mem_wren`=4'b1111, forced while `rstd`=0 regardless of `cpu_wren`.
  - `cpu_stall`=0, `host_ack`=0, `host_done`=0, `host_busy`=0.
- Reset mid-burst aborts the burst. No partial beat is written once `rstd`=0, and no `host_done` is issued.
- `host_len`=0: a single HOST cycle with `host_done`=1, then IDLE.

## Configuration
- `DMEM_ARB_STATS_EN` defined adds two outputs, both cleared by reset:
  - `stat_stall_cycles` (16 bits): cycles with `cpu_stall`=1, saturating at 16'hffff.
  - `stat_bursts` (8 bits): completed bursts, incremented on `host_done`, wrapping.
- `DMEM_ARB_STATS_EN` undefined: both ports and their logic are absent; the remaining behaviour is identical.

## Structure
- Package `dmem_arb_pkg` holds:
  - State encoding: IDLE=2'd0, HOST=2'd1, YIELD=2'd2.
  - `WREN_NONE`=4'b1111, `WREN_ALL`=4'b0000.
  - Address width 8 and data width 32.
- One sub-module, `dmem_arb_stats`, contains the statistics counters and is instantiated only under `DMEM_ARB_STATS_EN`.
- The FSM and the port mux stay in `dmem_arbiter`.

## Test plan
- Reset with `cpu_req`=1 and `cpu_wren`=4'b0000 → `mem_wren`=4'b1111 while `rstd`=0; after release the CPU stores 32'hdeadbeef to address 8 and a read of address 8 returns it with no stall.
- Host write burst: base 8'hfe, len 3, data 1,2,3,4 → words land at fe, ff, 00, 01 (wrap); `host_done` on the 4th ack; `cpu_stall` stays 0 throughout with `cpu_req`=0.
- Host read burst of 16 beats with `cpu_req` held high and `STARVE_LIMIT`=4 → yields after every 4 stalled cycles; total 19 cycles from first beat to `host_done`; CPU sees 3 unstalled cycles.
- `host_req` and a CPU store asserted together in IDLE → CPU store commits that cycle; first host beat occurs next cycle.
- `rstd` pulsed low during beat 2 of a 6-beat write burst → beats 0–1 written, beats 2–5 untouched; state IDLE; no `host_done`.
- With `DMEM_ARB_STATS_EN` defined: two bursts plus 5 stalled cycles → `stat_bursts`=2, `stat_stall_cycles`=5.
